qpsk_bit_splitter: RTL and testbench

- Upstream stage of the QPSK modulator. Accepts a serial bitstream through a valid/ready handshake and pairs consecutive bits into (E, O) dibits.
- Buffers the dibits in a small FIFO. Presents each dibit on E/O, held stable for exactly SYMBOL_LEN clocks (one carrier period of the 100-sample modulator LUT).
- Emits a one-cycle symbol strobe at each symbol boundary, used for carrier-phase alignment.

---
 rtl/qpsk_bit_splitter.sv | 163 ++++++++++++++++
 tb/tb_qpsk_bit_splitter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_bit_splitter.sv
// Serial-to-dibit splitter for the QPSK modulator: pairs handshaked bits into (E, O),
// queues them in a small FIFO and holds each dibit for SYMBOL_LEN clocks with a boundary strobe.
module qpsk_bit_splitter #(
    parameter int unsigned SYMBOL_LEN = 100,
    parameter int unsigned CNT_W      = 7,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        IDLE_E     = 1'b1,
    parameter logic        IDLE_O     = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    input  logic                          clr_underrun,
    output logic                          E,
    output logic                          O,
    output logic                          sym_strobe,
    output logic                          sym_active,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic               e_q, e_d, o_q, o_d;
    logic               strobe_q, strobe_d;
    logic               active_q, active_d;
    logic               underrun_q, underrun_d;
    logic               half_v_q, half_v_d;
    logic               half_bit_q, half_bit_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [1:0]         mem_q [FIFO_DEPTH];
    logic [1:0]         mem_d [FIFO_DEPTH];
    logic               accept, push, pop;
    logic [1:0]         head;

    // Ready depends only on registered state; a full FIFO is never bypassed by a same-cycle pop.
    assign bit_ready = !half_v_q || (level_q < LVL_W'(FIFO_DEPTH));
    assign accept    = bit_valid && bit_ready;
    assign push      = accept && half_v_q;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        e_d        = e_q;
        o_d        = o_q;
        strobe_d   = 1'b0;
        active_d   = active_q;
        underrun_d = underrun_q && !clr_underrun;
        half_v_d   = half_v_q;
        half_bit_d = half_bit_q;
        wr_ptr_d   = wr_ptr_q;
        mem_d      = mem_q;
        pop        = 1'b0;

        if (accept) begin
            if (!half_v_q) begin
                half_v_d   = 1'b1;
                half_bit_d = bit_in;
            end else begin
                half_v_d        = 1'b0;
                mem_d[wr_ptr_q] = {half_bit_q, bit_in};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                sym_cnt_d = '0;
                e_d       = IDLE_E;
                o_d       = IDLE_O;
                active_d  = 1'b0;
                if (level_q != '0) begin
                    pop      = 1'b1;
                    e_d      = head[1];
                    o_d      = head[0];
                    strobe_d = 1'b1;
                    active_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (sym_cnt_q == LAST_CNT) begin
                    sym_cnt_d = '0;
                    if (level_q != '0) begin
                        pop      = 1'b1;
                        e_d      = head[1];
                        o_d      = head[0];
                        strobe_d = 1'b1;
                    end else begin
                        e_d        = IDLE_E;
                        o_d        = IDLE_O;
                        active_d   = 1'b0;
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            sym_cnt_q  <= '0;
            e_q        <= IDLE_E;
            o_q        <= IDLE_O;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
            underrun_q <= 1'b0;
            half_v_q   <= 1'b0;
            half_bit_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            e_q        <= e_d;
            o_q        <= o_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
            underrun_q <= underrun_d;
            half_v_q   <= half_v_d;
            half_bit_q <= half_bit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mem_q      <= mem_d;
        end
    end

    assign E          = e_q;
    assign O          = o_q;
    assign sym_strobe = strobe_q;
    assign sym_active = active_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// Directed bench for qpsk_bit_splitter: a per-cycle vector table for reset and first pair,
// then hand-written sequences for symbol timing, FIFO fill, stalls, underrun and async reset.
module tb_qpsk_bit_splitter;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       clr_underrun = 1'b0;
    logic       E, O, sym_strobe, sym_active, underrun;
    logic [2:0] fifo_level;

    int checks = 0;
    int passed = 0;

    qpsk_bit_splitter #(
        .SYMBOL_LEN(100),
        .CNT_W(7),
        .FIFO_DEPTH(4),
        .IDLE_E(1'b1),
        .IDLE_O(1'b1)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .clr_underrun(clr_underrun),
        .E(E),
        .O(O),
        .sym_strobe(sym_strobe),
        .sym_active(sym_active),
        .underrun(underrun),
        .fifo_level(fifo_level)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit rst_n;
        bit valid;
        bit din;
        bit ready;
        bit e;
        bit o;
        bit strobe;
        bit active;
        int level;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        bit_valid = 1'b0;
        clr_underrun = 1'b0;
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
    endtask

    task automatic send_bit(input bit b);
        bit_valid = 1'b1;
        bit_in = b;
        step();
        bit_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int strobes[$];
        int waited;
        bit exp_e, exp_o;
        bit pe [3];
        bit po [3];
        bit sbits [6];

        // ---- Reset with bit_valid high, then first pair (vector table) ----
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};

        #2;
        for (int i = 0; i < 8; i++) begin
            Rst_n = tbl[i].rst_n;
            bit_valid = tbl[i].valid;
            bit_in = tbl[i].din;
            step();
            chk($sformatf("t1[%0d].ready", i), int'(bit_ready), int'(tbl[i].ready));
            chk($sformatf("t1[%0d].E", i), int'(E), int'(tbl[i].e));
            chk($sformatf("t1[%0d].O", i), int'(O), int'(tbl[i].o));
            chk($sformatf("t1[%0d].strobe", i), int'(sym_strobe), int'(tbl[i].strobe));
            chk($sformatf("t1[%0d].active", i), int'(sym_active), int'(tbl[i].active));
            chk($sformatf("t1[%0d].level", i), int'(fifo_level), tbl[i].level);
        end
        bit_valid = 1'b0;

        // ---- Stream 1,0,0,1,1,1 back-to-back: three symbols then underrun ----
        reset_dut();
        sbits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        pe = '{1'b1, 1'b0, 1'b1};
        po = '{1'b0, 1'b1, 1'b1};
        errs = 0;
        for (int c = 1; c <= 320; c++) begin
            bit_valid = (c <= 6);
            bit_in = (c <= 6) ? sbits[c-1] : 1'b0;
            step();
            if (sym_strobe) strobes.push_back(c);
            if (c >= 3 && c - 3 < 300) begin
                exp_e = pe[(c-3)/100];
                exp_o = po[(c-3)/100];
                if (E !== exp_e || O !== exp_o || sym_active !== 1'b1 ||
                    sym_strobe !== ((c-3) % 100 == 0) || underrun !== 1'b0) errs++;
            end else if (c < 3) begin
                if (E !== 1'b1 || O !== 1'b1 || sym_active !== 1'b0 || sym_strobe !== 1'b0) errs++;
            end else begin
                if (E !== 1'b1 || O !== 1'b1 || sym_active !== 1'b0 ||
                    sym_strobe !== 1'b0 || underrun !== 1'b1) errs++;
            end
        end
        bit_valid = 1'b0;
        chk("t2.cycle_errors", errs, 0);
        chk("t2.strobe_count", strobes.size(), 3);
        if (strobes.size() == 3) begin
            chk("t2.first_strobe_cycle", strobes[0], 3);
            chk("t2.strobe_gap1", strobes[1] - strobes[0], 100);
            chk("t2.strobe_gap2", strobes[2] - strobes[1], 100);
        end
        chk("t2.final_underrun", int'(underrun), 1);
        chk("t2.final_active", int'(sym_active), 0);
        chk("t2.final_EO", int'({E, O}), 3);

        // ---- Fill while RUN: FIFO reaches 4, bit held off until the next boundary ----
        reset_dut();
        send_bit(1'b1);
        send_bit(1'b0);
        step();
        chk("t3.load_strobe", int'(sym_strobe), 1);
        sbits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) send_bit(sbits[i]);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("t3.level_full", int'(fifo_level), 4);
        chk("t3.ready_blocked", int'(bit_ready), 0);
        chk("t3.half_v", int'(dut.half_v_q), 1);
        bit_valid = 1'b1;
        bit_in = 1'b1;
        waited = 0;
        while (waited < 200) begin
            step();
            waited++;
            if (bit_ready) break;
        end
        chk("t3.wait_cycles", waited, 91);
        chk("t3.boundary_strobe", int'(sym_strobe), 1);
        chk("t3.second_dibit", int'({E, O}), 1);
        chk("t3.level_after_pop", int'(fifo_level), 3);
        step();
        bit_valid = 1'b0;
        chk("t3.level_after_push", int'(fifo_level), 4);
        chk("t3.half_cleared", int'(dut.half_v_q), 0);

        // ---- Single bit then long stall ----
        reset_dut();
        send_bit(1'b0);
        chk("t4.half_v", int'(dut.half_v_q), 1);
        errs = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (E !== 1'b1 || O !== 1'b1 || sym_strobe !== 1'b0 || fifo_level !== 3'd0) errs++;
        end
        chk("t4.stall_errors", errs, 0);
        send_bit(1'b1);
        chk("t4.level_after_pair", int'(fifo_level), 1);
        chk("t4.no_early_strobe", int'(sym_strobe), 0);
        step();
        chk("t4.load_strobe", int'(sym_strobe), 1);
        chk("t4.load_EO", int'({E, O}), 1);
        for (int i = 0; i < 99; i++) step();
        chk("t4.cnt_last", int'(dut.sym_cnt_q), 99);
        chk("t4.still_active", int'(sym_active), 1);
        step();
        chk("t4.underrun_set", int'(underrun), 1);
        chk("t4.idle_EO", int'({E, O}), 3);

        // ---- Underrun clear: simultaneous set wins, then plain clear ----
        send_bit(1'b1);
        send_bit(1'b1);
        step();
        chk("t5.load_strobe", int'(sym_strobe), 1);
        for (int i = 0; i < 99; i++) step();
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("t5.set_wins", int'(underrun), 1);
        chk("t5.back_idle", int'(sym_active), 0);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("t5.cleared", int'(underrun), 0);
        step();
        chk("t5.stays_cleared", int'(underrun), 0);

        // ---- Asynchronous reset mid-symbol with queued data and half pair ----
        reset_dut();
        send_bit(1'b1);
        send_bit(1'b0);
        step();
        sbits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) send_bit(sbits[i]);
        send_bit(1'b1);
        for (int i = 0; i < 30; i++) step();
        chk("t6.cnt_pre", int'(dut.sym_cnt_q), 37);
        chk("t6.level_pre", int'(fifo_level), 3);
        chk("t6.half_pre", int'(dut.half_v_q), 1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t6.async_EO", int'({E, O}), 3);
        chk("t6.async_strobe", int'(sym_strobe), 0);
        chk("t6.async_active", int'(sym_active), 0);
        chk("t6.async_level", int'(fifo_level), 0);
        chk("t6.async_ready", int'(bit_ready), 1);
        chk("t6.async_half", int'(dut.half_v_q), 0);
        step();
        Rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        step();
        chk("t6.new_strobe", int'(sym_strobe), 1);
        chk("t6.new_EO", int'({E, O}), 3);
        chk("t6.new_cnt", int'(dut.sym_cnt_q), 0);
        chk("t6.new_level", int'(fifo_level), 0);
        step();
        chk("t6.cnt_next", int'(dut.sym_cnt_q), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
